regfile_wb_scheduler: RTL and testbench

- Owns the single write port of the 32x32 register file and sequences writes from two sources:
  - the core writeback path (ALU result, load data, JAL link), which normally cannot stall;
  - the IO/debug return path (slow IO loads, UART register preload), which is asynchronous to the core.
- IO writes are buffered in a small FIFO and drained in idle writeback slots.
- A starvation limit forces a one-cycle core stall to drain the FIFO.
- Reports read-after-write hazards against buffered writes so the controller can stall dependent instructions.

---
 rtl/regfile_wb_scheduler_pkg.sv | 19 +
 rtl/regfile_wb_scheduler_io_fifo.sv | 84 ++++++++
 rtl/regfile_wb_scheduler.sv | 127 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file writeback definitions.
// Used by the scheduler top and by its IO write FIFO.
package regfile_wb_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  // Owner of the register-file write slot in the current cycle.
  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_CORE,
    SLOT_IO,
    SLOT_FORCED
  } slot_e;

endpackage

// File: rtl/regfile_wb_scheduler_io_fifo.sv
// Buffer for IO/debug register writes.
// Each entry has a live bit, and an accepted core write to the same register clears it.
module wb_io_fifo
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic [REG_ADDR_W-1:0]         i_waddr,
  input  logic [DATA_W-1:0]             i_wdata,
  input  logic                          i_pop,
  input  logic                          i_kill,
  input  logic [REG_ADDR_W-1:0]         i_kill_addr,
  input  logic [REG_ADDR_W-1:0]         i_rs_addr,
  input  logic [REG_ADDR_W-1:0]         i_rt_addr,
  output logic                          o_head_live,
  output logic [REG_ADDR_W-1:0]         o_head_waddr,
  output logic [DATA_W-1:0]             o_head_wdata,
  output logic [$clog2(DEPTH+1)-1:0]    o_count,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [DEPTH-1:0]              o_match
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [REG_ADDR_W-1:0] r_waddr [DEPTH];
  logic [DATA_W-1:0]     r_wdata [DEPTH];
  logic [DEPTH-1:0]      r_live;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DEPTH-1:0]      w_live_next;

  // Kill first, then pop, then push: a same-cycle push to the killed register is newer.
  always_comb begin
    w_live_next = r_live;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_kill && (r_waddr[i] == i_kill_addr)) w_live_next[i] = 1'b0;
    end
    if (i_pop)  w_live_next[r_rd_ptr] = 1'b0;
    if (i_push) w_live_next[r_wr_ptr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= '0;
    end else begin
      if (i_push) begin
        r_waddr[r_wr_ptr] <= i_waddr;
        r_wdata[r_wr_ptr] <= i_wdata;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_live <= w_live_next;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = r_live[i] && (r_waddr[i] != REG_ZERO) &&
                   ((r_waddr[i] == i_rs_addr) || (r_waddr[i] == i_rt_addr));
    end
  end

  assign o_head_live  = r_live[r_rd_ptr];
  assign o_head_waddr = r_waddr[r_rd_ptr];
  assign o_head_wdata = r_wdata[r_rd_ptr];
  assign o_count      = r_count;
  assign o_full       = (r_count == CNT_W'(DEPTH));
  assign o_empty      = (r_count == '0);

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: the core writeback has priority and IO writes fill idle slots.
// If the FIFO head waits too long, the core is stalled for one cycle so the head can drain.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          core_we,
  input  logic [REG_ADDR_W-1:0]         core_waddr,
  input  logic [DATA_W-1:0]             core_wdata,
  input  logic                          io_valid,
  output logic                          io_ready,
  input  logic [REG_ADDR_W-1:0]         io_waddr,
  input  logic [DATA_W-1:0]             io_wdata,
  input  logic [REG_ADDR_W-1:0]         rs_addr,
  input  logic [REG_ADDR_W-1:0]         rt_addr,
  output logic                          stall_core,
  output logic                          pending_hazard,
  output logic                          rf_we,
  output logic [REG_ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_count
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT+1);

  logic                  w_push;
  logic                  w_pop;
  logic                  w_core_win;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_head_live;
  logic [REG_ADDR_W-1:0] w_head_waddr;
  logic [DATA_W-1:0]     w_head_wdata;
  logic [DEPTH-1:0]      w_match;
  slot_e                 w_slot;
  logic                  w_sel_live;
  logic [REG_ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0]     w_sel_data;

  logic [STARVE_W-1:0]   r_starve;
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0]     r_rf_wdata;

  wb_io_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .i_push       (w_push),
    .i_waddr      (io_waddr),
    .i_wdata      (io_wdata),
    .i_pop        (w_pop),
    .i_kill       (w_core_win),
    .i_kill_addr  (core_waddr),
    .i_rs_addr    (rs_addr),
    .i_rt_addr    (rt_addr),
    .o_head_live  (w_head_live),
    .o_head_waddr (w_head_waddr),
    .o_head_wdata (w_head_wdata),
    .o_count      (fifo_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_match      (w_match)
  );

  always_comb begin
    w_slot = SLOT_IDLE;
    if (!w_empty && (r_starve == STARVE_W'(STARVE_LIMIT))) w_slot = SLOT_FORCED;
    else if (core_we)                                       w_slot = SLOT_CORE;
    else if (!w_empty)                                      w_slot = SLOT_IO;
  end

  always_comb begin
    w_sel_live = 1'b0;
    w_sel_addr = REG_ZERO;
    w_sel_data = '0;
    case (w_slot)
      SLOT_CORE: begin
        w_sel_live = 1'b1;
        w_sel_addr = core_waddr;
        w_sel_data = core_wdata;
      end
      SLOT_IO, SLOT_FORCED: begin
        w_sel_live = w_head_live;
        w_sel_addr = w_head_waddr;
        w_sel_data = w_head_wdata;
      end
      default: ;
    endcase
  end

  assign w_core_win = (w_slot == SLOT_CORE);
  assign w_pop      = (w_slot == SLOT_IO) || (w_slot == SLOT_FORCED);
  assign io_ready   = !w_full;
  assign w_push     = io_valid && io_ready;

  always_ff @(posedge clock) begin
    if (reset)                  r_starve <= '0;
    else if (w_empty || w_pop)  r_starve <= '0;
    else if (r_starve != STARVE_W'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
  end

  // Address and data hold while the slot is idle; only the write enable drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= REG_ZERO;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_sel_live && (w_sel_addr != REG_ZERO);
      if (w_slot != SLOT_IDLE) begin
        r_rf_waddr <= w_sel_addr;
        r_rf_wdata <= w_sel_data;
      end
    end
  end

  assign stall_core     = (w_slot == SLOT_FORCED);
  assign pending_hazard = |w_match;
  assign rf_we          = r_rf_we;
  assign rf_waddr       = r_rf_waddr;
  assign rf_wdata       = r_rf_wdata;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: core writes, IO drains, starvation, kill, backpressure and reset.
module tb_regfile_wb_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_we;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata;
  logic        io_valid;
  logic        io_ready;
  logic [4:0]  io_waddr;
  logic [31:0] io_wdata;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        stall_core;
  logic        pending_hazard;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  fifo_count;

  int n_total = 0;
  int n_bad   = 0;

  regfile_wb_scheduler dut (
    .clock          (clock),
    .reset          (reset),
    .core_we        (core_we),
    .core_waddr     (core_waddr),
    .core_wdata     (core_wdata),
    .io_valid       (io_valid),
    .io_ready       (io_ready),
    .io_waddr       (io_waddr),
    .io_wdata       (io_wdata),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .stall_core     (stall_core),
    .pending_hazard (pending_hazard),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .fifo_count     (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    io_valid = 1'b1;
    io_waddr = a;
    io_wdata = d;
    step();
    io_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; core_we = 1'b0; core_waddr = '0; core_wdata = '0;
    io_valid = 1'b0; io_waddr = '0; io_wdata = '0; rs_addr = '0; rt_addr = '0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", io_ready, 1);
    chk("rst_stall", stall_core, 0);
    chk("rst_hazard", pending_hazard, 0);

    // core-only write
    core_we = 1'b1; core_waddr = 5; core_wdata = 32'h1234;
    #1 chk("t1_stall", stall_core, 0);
    step();
    core_we = 1'b0;
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'h1234);
    chk("t1_stall2", stall_core, 0);
    step();
    chk("t1_we_off", rf_we, 0);

    // idle drain
    push(7, 32'hAAAA);
    rs_addr = 7;
    #1;
    chk("t2_count1", fifo_count, 1);
    chk("t2_hazard", pending_hazard, 1);
    step();
    chk("t2_we", rf_we, 1);
    chk("t2_waddr", rf_waddr, 7);
    chk("t2_wdata", rf_wdata, 32'hAAAA);
    chk("t2_count0", fifo_count, 0);
    chk("t2_hazard0", pending_hazard, 0);
    rs_addr = 0;

    // starvation forced drain
    core_we = 1'b1; core_waddr = 4; core_wdata = 32'h44;
    push(3, 32'h33);
    chk("t3_count", fifo_count, 1);
    chk("t3_core_waddr", rf_waddr, 4);
    for (int i = 0; i < 8; i++) begin
      chk("t3_nostall", stall_core, 0);
      step();
    end
    chk("t3_stall", stall_core, 1);
    step();
    chk("t3_drain_we", rf_we, 1);
    chk("t3_drain_waddr", rf_waddr, 3);
    chk("t3_drain_wdata", rf_wdata, 32'h33);
    chk("t3_stall_once", stall_core, 0);
    chk("t3_count0", fifo_count, 0);
    step();
    chk("t3_core_back_waddr", rf_waddr, 4);
    chk("t3_core_back_wdata", rf_wdata, 32'h44);
    chk("t3_core_back_we", rf_we, 1);
    core_we = 1'b0;
    step();

    // ordering kill
    core_we = 1'b1; core_waddr = 10; core_wdata = 32'hA;
    push(9, 32'h1);
    rs_addr = 9;
    core_waddr = 9; core_wdata = 32'h2;
    #1 chk("t4_hazard", pending_hazard, 1);
    step();
    core_we = 1'b0;
    chk("t4_core_waddr", rf_waddr, 9);
    chk("t4_core_wdata", rf_wdata, 32'h2);
    chk("t4_hazard_gone", pending_hazard, 0);
    chk("t4_count1", fifo_count, 1);
    step();
    chk("t4_dead_pop_we", rf_we, 0);
    chk("t4_count0", fifo_count, 0);
    rs_addr = 0;

    // same-cycle push to the core register stays live
    core_we = 1'b1; core_waddr = 12; core_wdata = 32'h6;
    push(12, 32'h5);
    core_we = 1'b0; rt_addr = 12;
    #1 chk("t4b_hazard_live", pending_hazard, 1);
    step();
    chk("t4b_we", rf_we, 1);
    chk("t4b_waddr", rf_waddr, 12);
    chk("t4b_wdata", rf_wdata, 32'h5);
    rt_addr = 0;

    // full FIFO, backpressure and $0
    core_we = 1'b1; core_waddr = 1; core_wdata = 32'h11;
    push(0, 32'hDEAD);
    push(20, 32'h20);
    push(21, 32'h21);
    push(22, 32'h22);
    chk("t5_count4", fifo_count, 4);
    chk("t5_ready0", io_ready, 0);
    io_valid = 1'b1; io_waddr = 23; io_wdata = 32'h23;
    repeat (5) step();
    chk("t5_held_count", fifo_count, 4);
    chk("t5_held_ready", io_ready, 0);
    chk("t5_stall", stall_core, 1);
    step();
    chk("t5_zero_we", rf_we, 0);
    chk("t5_zero_waddr", rf_waddr, 0);
    chk("t5_count3", fifo_count, 3);
    chk("t5_ready1", io_ready, 1);
    step();
    io_valid = 1'b0; core_we = 1'b0;
    chk("t5_count_refill", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_drain_we", rf_we, 1);
      chk("t5_drain_waddr", rf_waddr, 20 + i);
      chk("t5_drain_wdata", rf_wdata, 32'h20 + i);
    end
    chk("t5_empty", fifo_count, 0);

    // reset mid-flight
    core_we = 1'b1; core_waddr = 2; core_wdata = 32'h2;
    push(13, 32'hD);
    push(14, 32'hE);
    push(15, 32'hF);
    chk("t6_count3", fifo_count, 3);
    reset = 1'b1;
    step();
    reset = 1'b0; core_we = 1'b0; rs_addr = 13;
    #1;
    chk("t6_count0", fifo_count, 0);
    chk("t6_ready", io_ready, 1);
    chk("t6_we_rst", rf_we, 0);
    chk("t6_hazard", pending_hazard, 0);
    step();
    chk("t6_we_after1", rf_we, 0);
    step();
    chk("t6_we_after2", rf_we, 0);
    chk("t6_count_stay", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
